// File: rtl/stage2_unpool_upsample_pkg.sv
// Shared widths and FSM encoding for the stage-2 unpool/upsample block.
package stage2_unpool_upsample_pkg;

  localparam int ST2_Unpool_IBW = 19;
  localparam int ST2_Unpool_X   = 12;
  localparam int ST2_Unpool_Y   = 12;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_DUP    = 2'd1,
    S_REPLAY = 2'd2
  } st2_unpool_state_e;

  // Index width for a counter over n positions (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage2_unpool_upsample_if.sv
// Ready/valid input and output streams of the stage-2 upsampler.
interface stage2_unpool_upsample_if
  import stage2_unpool_upsample_pkg::*;
#(
  parameter int IBW = ST2_Unpool_IBW
);

  logic           i_in_valid;
  logic           o_in_ready;
  logic [IBW-1:0] i_in_fmap;
  logic           o_ot_valid;
  logic           i_ot_ready;
  logic [IBW-1:0] o_ot_fmap;
  logic           o_ot_last;

  modport slave (
    input  i_in_valid, i_in_fmap, i_ot_ready,
    output o_in_ready, o_ot_valid, o_ot_fmap, o_ot_last
  );

  modport master (
    output i_in_valid, i_in_fmap, i_ot_ready,
    input  o_in_ready, o_ot_valid, o_ot_fmap, o_ot_last
  );

endinterface

// File: rtl/stage2_unpool_linebuf.sv
// One-row pixel store: written by column during the load pass, read back for the replay row.
module stage2_unpool_linebuf
  import stage2_unpool_upsample_pkg::*;
#(
  parameter int IBW   = ST2_Unpool_IBW,
  parameter int DEPTH = ST2_Unpool_X,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [IBW-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [IBW-1:0] rdata
);

  logic [IBW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (int'(raddr) < DEPTH) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/stage2_unpool_upsample.sv
// 2x nearest-neighbour upsampler: each input pixel becomes a 2x2 output block.
module stage2_unpool_upsample
  import stage2_unpool_upsample_pkg::*;
#(
  parameter int IBW  = ST2_Unpool_IBW,
  parameter int IN_X = ST2_Unpool_X,
  parameter int IN_Y = ST2_Unpool_Y
) (
  input  logic                     clk,
  input  logic                     reset,
  stage2_unpool_upsample_if.slave  bus
);

  localparam int unsigned CW = idx_width(IN_X);
  localparam int unsigned RW = idx_width(IN_Y);
  localparam logic [CW-1:0] LAST_COL = CW'(IN_X - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IN_Y - 1);

  st2_unpool_state_e state;
  logic [CW-1:0]  col;
  logic [CW-1:0]  rcol;
  logic [RW-1:0]  row;
  logic           phase;
  logic [IBW-1:0] hold;
  logic [IBW-1:0] ot_fmap;
  logic           ot_valid;
  logic           ot_last;
  logic [IBW-1:0] lb_rdata;
  logic           adv;
  logic           in_rdy;
  logic           in_xfer;

  assign adv     = !ot_valid || bus.i_ot_ready;
  assign in_rdy  = (state == S_LOAD) && adv;
  assign in_xfer = bus.i_in_valid && in_rdy;

  stage2_unpool_linebuf #(
    .IBW   (IBW),
    .DEPTH (IN_X),
    .AW    (int'(CW))
  ) u_linebuf (
    .clk   (clk),
    .we    (in_xfer),
    .waddr (col),
    .wdata (bus.i_in_fmap),
    .raddr (rcol),
    .rdata (lb_rdata)
  );

  // Output register only moves when the current beat is gone or was never valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_LOAD;
      col      <= '0;
      rcol     <= '0;
      row      <= '0;
      phase    <= 1'b0;
      hold     <= '0;
      ot_fmap  <= '0;
      ot_valid <= 1'b0;
      ot_last  <= 1'b0;
    end else if (adv) begin
      unique case (state)
        S_LOAD: begin
          ot_last <= 1'b0;
          if (bus.i_in_valid) begin
            hold     <= bus.i_in_fmap;
            ot_fmap  <= bus.i_in_fmap;
            ot_valid <= 1'b1;
            state    <= S_DUP;
          end else begin
            ot_valid <= 1'b0;
          end
        end
        S_DUP: begin
          ot_fmap  <= hold;
          ot_valid <= 1'b1;
          ot_last  <= 1'b0;
          if (col == LAST_COL) begin
            col   <= '0;
            rcol  <= '0;
            phase <= 1'b0;
            state <= S_REPLAY;
          end else begin
            col   <= col + CW'(1);
            state <= S_LOAD;
          end
        end
        S_REPLAY: begin
          // Odd output row: each stored pixel is emitted twice (phase 0 then 1).
          ot_fmap  <= lb_rdata;
          ot_valid <= 1'b1;
          phase    <= ~phase;
          ot_last  <= phase && (rcol == LAST_COL) && (row == LAST_ROW);
          if (phase) begin
            if (rcol == LAST_COL) begin
              state <= S_LOAD;
              row   <= (row == LAST_ROW) ? '0 : row + RW'(1);
            end else begin
              rcol <= rcol + CW'(1);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign bus.o_in_ready = in_rdy;
  assign bus.o_ot_valid = ot_valid;
  assign bus.o_ot_fmap  = ot_fmap;
  assign bus.o_ot_last  = ot_last;

endmodule

// File: tb/tb_stage2_unpool_upsample.sv
// Randomised bench for stage2_unpool_upsample against a frame-level 2x2 replication model.
module tb_stage2_unpool_upsample;
  import stage2_unpool_upsample_pkg::*;

  localparam int IBW   = ST2_Unpool_IBW;
  localparam int NX    = ST2_Unpool_X;
  localparam int NY    = ST2_Unpool_Y;
  localparam int OX    = 2 * NX;
  localparam int OY    = 2 * NY;
  localparam int BEATS = OX * OY;
  localparam int NPIX  = NX * NY;
  localparam int FRAME_LIMIT = 20000;

  typedef struct {
    logic [IBW-1:0] d;
    logic           l;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stage2_unpool_upsample_if #(.IBW(IBW)) bus ();

  stage2_unpool_upsample #(
    .IBW  (IBW),
    .IN_X (NX),
    .IN_Y (NY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [IBW-1:0] pix [NPIX];
  beat_t exp_q[$];

  // kind 0: pixel(r,c) = r*NX+c; kind 1: random with sign corner values up front
  task automatic build_frame(input int kind);
    beat_t b;
    for (int i = 0; i < NPIX; i++) begin
      pix[i] = (kind == 0) ? IBW'(i) : IBW'($urandom);
    end
    if (kind == 1) begin
      pix[0] = 19'h40000;
      pix[1] = 19'h7FFFF;
      pix[2] = 19'h3FFFF;
    end
    for (int y = 0; y < OY; y++) begin
      for (int x = 0; x < OX; x++) begin
        b.d = pix[(y / 2) * NX + (x / 2)];
        b.l = (y == OY - 1) && (x == OX - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Monitor state, cleared while reset is held.
  int    tot_in = 0;
  int    tot_out = 0;
  int    bubbles = 0;
  logic  stall_prev = 1'b0;
  logic [IBW-1:0] stall_d;
  logic  stall_l;
  int    pos;
  logic  adv_m;
  logic  exp_rdy;
  beat_t eb;

  always @(negedge clk) begin
    if (!reset) begin
      adv_m   = !bus.o_ot_valid || bus.i_ot_ready;
      pos     = (tot_out + int'(bus.o_ot_valid)) % BEATS;
      exp_rdy = adv_m && (((pos / OX) % 2) == 0) && (((pos % OX) % 2) == 0);
      check_val("in_ready", 64'(bus.o_in_ready), 64'(exp_rdy));

      if (stall_prev) begin
        check_val("stall_valid", 64'(bus.o_ot_valid), 64'd1);
        check_val("stall_fmap", 64'(bus.o_ot_fmap), 64'(stall_d));
        check_val("stall_last", 64'(bus.o_ot_last), 64'(stall_l));
      end
      stall_prev = bus.o_ot_valid && !bus.i_ot_ready;
      stall_d    = bus.o_ot_fmap;
      stall_l    = bus.o_ot_last;

      if (!bus.o_ot_valid && (tot_out % BEATS) != 0) bubbles++;

      if (bus.o_ot_valid && bus.i_ot_ready) begin
        check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          eb = exp_q.pop_front();
          check_val("ot_fmap", 64'(bus.o_ot_fmap), 64'(eb.d));
          check_val("ot_last", 64'(bus.o_ot_last), 64'(eb.l));
        end
        if ((tot_out % (2 * OX)) == 2 * OX - 1) begin
          check_val("row_inputs", 64'(tot_in), 64'(NX * (tot_out / (2 * OX) + 1)));
        end
        tot_out++;
      end
      if (bus.i_in_valid && bus.o_in_ready) tot_in++;
    end
  end

  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  // vmode: 0 always valid, 1 four-cycle gap after pixel (0,5), 2 random.
  task automatic run_frame(input int rmode, input int vmode, input int abort_after);
    int cyc = 0;
    int idx;
    int gap = 0;
    bit gap_done = 1'b0;
    bit v;
    int base_in  = tot_in;
    int base_out = tot_out;
    bubbles = 0;
    while ((tot_out - base_out) < BEATS && cyc < FRAME_LIMIT &&
           !(abort_after > 0 && (tot_in - base_in) >= abort_after)) begin
      idx = tot_in - base_in;
      v = (idx < NPIX);
      if (vmode == 1 && idx == 6 && !gap_done) begin
        gap = 4;
        gap_done = 1'b1;
      end
      if (gap > 0) begin
        v = 1'b0;
        gap--;
      end
      if (vmode == 2 && $urandom_range(0, 3) == 0) v = 1'b0;
      bus.i_in_valid = v;
      bus.i_in_fmap  = v ? pix[idx] : IBW'($urandom);
      case (rmode)
        0:       bus.i_ot_ready = 1'b1;
        1:       bus.i_ot_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.i_ot_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.i_in_valid = 1'b0;
    if (abort_after == 0) begin
      check_val("frame_done", 64'(cyc < FRAME_LIMIT), 64'd1);
      check_val("frame_inputs", 64'(tot_in - base_in), 64'(NPIX));
      check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    reset          = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_in_fmap  = '0;
    bus.i_ot_ready = 1'b1;
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("rst_valid", 64'(bus.o_ot_valid), 64'd0);
    check_val("rst_fmap", 64'(bus.o_ot_fmap), 64'd0);
    check_val("rst_last", 64'(bus.o_ot_last), 64'd0);
    #2 reset = 1'b0;
    #1 check_val("rst_in_ready", 64'(bus.o_in_ready), 64'd1);
    @(posedge clk);
    #1;

    build_frame(0);
    run_frame(0, 0, 0);
    check_val("bubbles_full", 64'(bubbles), 64'd0);

    build_frame(0);
    run_frame(1, 0, 0);

    build_frame(1);
    run_frame(2, 2, 0);

    build_frame(0);
    run_frame(0, 1, 0);
    check_val("bubbles_gap", 64'(bubbles), 64'd3);

    // Abort mid-frame with reset, then a fresh frame must start at pixel (0,0).
    build_frame(0);
    run_frame(0, 0, 30);
    #2 reset = 1'b1;
    #1;
    check_val("arst_valid", 64'(bus.o_ot_valid), 64'd0);
    check_val("arst_fmap", 64'(bus.o_ot_fmap), 64'd0);
    check_val("arst_last", 64'(bus.o_ot_last), 64'd0);
    exp_q.delete();
    tot_in     = 0;
    tot_out    = 0;
    stall_prev = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    build_frame(1);
    run_frame(2, 0, 0);
    build_frame(0);
    run_frame(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage2_unpool_upsample.md
Name: stage2_unpool_upsample

Overview:
- Inverse of the stage-2 2x2 max-pool stage: 2x nearest-neighbour upsampler for one feature-map channel.
- Accepts a raster stream of IN_X x IN_Y pooled pixels and emits a raster stream of (2*IN_X) x (2*IN_Y) pixels.
- Every input pixel is replicated into a 2x2 output block.
- Sits on the decoder/reconstruction side of the CNN datapath. Uses a one-row line buffer and a small FSM with ready/valid flow control on both sides.

Parameters:
- IBW, 19, pixel width in bits (signed two's complement, passed through bit-exact)
- IN_X, 12, input columns per row
- IN_Y, 12, input rows per frame

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- i_in_valid  input  1  input pixel valid
- o_in_ready  output  1  block accepts input this cycle (transfer = i_in_valid & o_in_ready)
- i_in_fmap  input  IBW  input pixel, raster order
- o_ot_valid  output  1  output pixel valid
- i_ot_ready  input  1  downstream accepts output (transfer = o_ot_valid & i_ot_ready)
- o_ot_fmap  output  IBW  output pixel, raster order
- o_ot_last  output  1  high with the final output pixel of a frame

Behaviour:
- Reset (async, active-high): state=S_LOAD, col=0, row=0, rcol=0, phase=0, hold=0. Outputs o_ot_valid=0, o_ot_fmap=0, o_ot_last=0. Line buffer contents are don't-care.
- adv = !o_ot_valid | i_ot_ready. The output register loads only when adv=1. While o_ot_valid & !i_ot_ready, o_ot_fmap and o_ot_last hold stable.
- S_LOAD:
  - o_in_ready = adv. In all other states o_in_ready=0.
  - On input transfer: lb[col]<=i_in_fmap, hold<=i_in_fmap, o_ot_fmap<=i_in_fmap, o_ot_valid<=1; go to S_DUP.
  - If adv and no input transfer: o_ot_valid<=0.
- S_DUP (on adv):
  - o_ot_fmap<=hold, o_ot_valid<=1.
  - If col==IN_X-1: col<=0, rcol<=0, phase<=0, go to S_REPLAY. Else col<=col+1, go to S_LOAD.
- S_REPLAY, odd output row (on adv):
  - o_ot_fmap<=lb[rcol], o_ot_valid<=1, phase<=~phase.
  - When phase==1: if rcol==IN_X-1, go to S_LOAD and row<=(row==IN_Y-1)?0:row+1; else rcol<=rcol+1.
- o_ot_last is loaded as 1 only on the S_REPLAY beat with phase==1, rcol==IN_X-1, row==IN_Y-1. It is 0 on every other loaded beat.
- Latency: input transfer to first copy on o_ot_fmap is 1 cycle.
- Throughput: each input row produces 4*IN_X output beats and IN_X input transfers. Input is stalled for at least 3*IN_X of those cycles.
- Input bubbles in S_LOAD produce output bubbles (o_ot_valid=0). Stream order is unaffected.
- Frame wrap: after the last beat the counters return to row 0 / col 0 in S_LOAD. No idle cycle is required between frames.
- Simultaneous backpressure and input: no input is accepted while adv=0, so data is never dropped.
- Reset mid-frame discards the partial frame. The first transfer after reset is treated as pixel (0,0).
- No arithmetic: widths are unchanged and values are copied verbatim, including negatives.

Decomposition:
- Shared package/defines file holds:
  - stage widths ST2_Unpool_IBW=19, ST2_Unpool_X=12, ST2_Unpool_Y=12
  - FSM state encodings S_LOAD/S_DUP/S_REPLAY
- One natural sub-module: stage2_unpool_linebuf, an IN_X x IBW single-write/single-read register array with write index col and read index rcol.
- FSM, counters and output register stay in the top module.

Test Plan:
- Full frame, i_ot_ready=1, input pixel(r,c)=r*12+c always valid:
  - 576 output beats; out(y,x)=(y>>1)*12+(x>>1).
  - o_ot_last high only on beat 576, value 143.
  - Exactly 144 input transfers.
- Backpressure, i_ot_ready pattern 1,0,0,1 repeating:
  - Output sequence identical to scenario 1.
  - o_ot_fmap/o_ot_last unchanged whenever valid & !ready.
  - o_in_ready=0 whenever adv=0.
- Sign pass-through: inputs 19'h40000, 19'h7FFFF, 19'h3FFFF:
  - Each appears bit-exact in its 2x2 block.
- Input gaps: deassert i_in_valid for 3 cycles after input pixel (0,5):
  - o_ot_valid drops for those cycles.
  - Row 0 output continues 5,5,6,6 once input resumes.
- Ready gating: i_in_valid held 1 continuously:
  - o_in_ready=0 throughout S_DUP and S_REPLAY.
  - Exactly 12 input transfers per 48 output beats.
- Reset after 30 input transfers:
  - Outputs go 0 asynchronously.
  - The next frame's first two beats equal the new pixel (0,0) and o_ot_last does not fire early.
